// File: rtl/rect_plotter.sv
// rect_plotter: pixel-write generator for a 160x120, 3-bit-colour frame buffer adapter.
// Each accepted start latches one rectangle command (or a full-screen clear). The block
// then issues one pixel per clock in row-major order. Pixels that fall off-screen still
// take a cycle, but plot stays low for them.
//
// Ports:
//   clock, resetn         - system clock; asynchronous active-low reset
//   start, clear          - command strobe (sampled in IDLE only); clear selects a full-screen fill
//   x0, y0, w, h          - rectangle origin and size (ignored when clear=1)
//   colour_in             - fill colour {R,G,B}
//   x, y, colour, plot    - registered pixel write to the adapter
//   busy, done            - busy from the cycle after accept until done; one-cycle done pulse
module rect_plotter #(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       clear,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [7:0] w,
    input  logic [6:0] h,
    input  logic [2:0] colour_in,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] ClearW = 8'(SCREEN_W);
    localparam logic [6:0] ClearH = 7'(SCREEN_H);
    localparam logic [8:0] LimitX = 9'(SCREEN_W);
    localparam logic [7:0] LimitY = 8'(SCREEN_H);

    typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] bx_q, bx_d, bw_q, bw_d, cx_q, cx_d;
    logic [6:0] by_q, by_d, bh_q, bh_d, cy_q, cy_d;
    logic [2:0] col_q, col_d;

    logic [7:0] x_d;
    logic [6:0] y_d;
    logic [2:0] colour_d;
    logic       plot_d, busy_d, done_d;
    logic [8:0] sum_x;
    logic [7:0] sum_y;

    // Next-state logic. The pixel outputs are computed from the *next* command and counter
    // values, so the registered outputs present pixel (cx,cy) in the same cycle the counters
    // hold it. That is why the first pixel shows the cycle after accept.
    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        bw_d    = bw_q;
        bh_d    = bh_q;
        col_d   = col_q;
        cx_d    = cx_q;
        cy_d    = cy_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (clear) begin
                        bx_d = '0;
                        by_d = '0;
                        bw_d = ClearW;
                        bh_d = ClearH;
                    end else begin
                        bx_d = x0;
                        by_d = y0;
                        bw_d = w;
                        bh_d = h;
                    end
                    col_d   = colour_in;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = (bw_d == '0 || bh_d == '0) ? StDone : StDraw;
                end
            end
            StDraw: begin
                if (cx_q == bw_q - 8'd1) begin
                    cx_d = '0;
                    if (cy_q == bh_q - 7'd1) begin
                        state_d = StDone;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Widened sums so an off-screen pixel never wraps back onto the screen.
        sum_x = {1'b0, bx_d} + {1'b0, cx_d};
        sum_y = {1'b0, by_d} + {1'b0, cy_d};

        x_d      = x;
        y_d      = y;
        colour_d = colour;
        plot_d   = 1'b0;
        if (state_d == StDraw) begin
            x_d      = sum_x[7:0];
            y_d      = sum_y[6:0];
            colour_d = col_d;
            plot_d   = (sum_x < LimitX) && (sum_y < LimitY);
        end
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            bx_q    <= '0;
            by_q    <= '0;
            bw_q    <= '0;
            bh_q    <= '0;
            col_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            plot    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            bw_q    <= bw_d;
            bh_q    <= bh_d;
            col_q   <= col_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            x       <= x_d;
            y       <= y_d;
            colour  <= colour_d;
            plot    <= plot_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule
